scaler_counter_scheduler: RTL and testbench

- Turns rising edges on selected scaler stage outputs (e.g. FS05…FS17 taps) into counter-increment requests for the involuntary counter cells (TIME1–TIME6, DOWNRUPT timing).
- Holds one pending flag per requester and grants at most one counter cycle per memory-cycle slot, using fixed priority.
- Runs a CTR_VLD/CTR_DONE handshake with the counter-cycle logic, and detects lost increments and stalled cycles.
- Sits between the scaler and the counter/sequence-generator logic.

---
 rtl/scaler_sched_pkg.sv | 25 ++
 rtl/scaler_edge_latch.sv | 64 ++++++
 rtl/scaler_counter_scheduler.sv | 161 ++++++++++++++++
 tb/tb_scaler_counter_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_sched_pkg.sv
// Shared types, constants and helpers for the scaler counter scheduler.
package scaler_sched_pkg;

  localparam int unsigned CYCLE_LEN_DEF = 12;
  localparam int unsigned TP_W          = 4;
  localparam int unsigned MAX_REQ       = 16;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_BUSY = 1'b1
  } sched_state_t;

  // Lowest set bit of vec as a one-hot vector; all zero when vec is zero.
  function automatic logic [MAX_REQ-1:0] onehot_lowest(input logic [MAX_REQ-1:0] vec);
    logic [MAX_REQ-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (vec[i] && (res == '0)) begin
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scaler_edge_latch.sv
// Per-requester tap edge detector with pending and sticky lost flags.
// SCALER_SCHED_LOSS_COUNT_EN exposes the per-clock lost event.
module scaler_edge_latch
  import scaler_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tap,
  input  logic en,
  input  logic gnt,
  input  logic retry,
  input  logic clr_lost,
  output logic pend,
  output logic lost
`ifdef SCALER_SCHED_LOSS_COUNT_EN
  ,
  output logic lost_evt
`endif
);

  logic prev_q;
  logic pend_q;
  logic lost_q;
  logic edge_det;
  logic lost_set;

  assign edge_det = tap & ~prev_q & en;
  // A bit being granted this clock is not counted as lost: the new edge is a fresh request.
  assign lost_set = edge_det & pend_q & ~gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= tap;
      pend_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      prev_q <= tap;

      if (!en) begin
        pend_q <= 1'b0;
      end else if (edge_det) begin
        pend_q <= 1'b1;
      end else if (gnt) begin
        pend_q <= 1'b0;
      end else if (retry) begin
        pend_q <= 1'b1;
      end

      if (lost_set) begin
        lost_q <= 1'b1;
      end else if (clr_lost) begin
        lost_q <= 1'b0;
      end
    end
  end

  assign pend = pend_q;
  assign lost = lost_q;

`ifdef SCALER_SCHED_LOSS_COUNT_EN
  assign lost_evt = lost_set;
`endif

endmodule

// File: rtl/scaler_counter_scheduler.sv
// Fixed-priority scheduler from scaler tap edges to involuntary counter cycles.
// SCALER_SCHED_LOSS_COUNT_EN adds the saturating LOSS_CNT output.
module scaler_counter_scheduler
  import scaler_sched_pkg::*;
#(
  parameter int unsigned NREQ          = 8,
  parameter int unsigned CYCLE_LEN     = CYCLE_LEN_DEF,
  parameter int unsigned TIMEOUT_SLOTS = 4
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic [NREQ-1:0] SCL_TAP,
  input  logic [NREQ-1:0] REQ_EN,
  input  logic            INHINC,
  input  logic            CTR_DONE,
  input  logic            CLR_LOST,
  output logic [3:0]      TP,
  output logic            CTR_VLD,
  output logic [NREQ-1:0] CTR_GNT,
  output logic [NREQ-1:0] PEND,
  output logic [NREQ-1:0] LOST,
  output logic            ERR
`ifdef SCALER_SCHED_LOSS_COUNT_EN
  ,
  output logic [7:0]      LOSS_CNT
`endif
);

  sched_state_t       state_q;
  logic [TP_W-1:0]    tp_q;
  logic               slot_end;
  logic               vld_q;
  logic [NREQ-1:0]    gnt_q;
  logic [3:0]         slot_cnt_q;
  logic               err_q;

  logic [NREQ-1:0]    pend;
  logic [NREQ-1:0]    lost;
  logic [NREQ-1:0]    pick;
  logic [NREQ-1:0]    gnt_now;
  logic [NREQ-1:0]    retry_vec;
  logic [MAX_REQ-1:0] pend_ext;
  logic [MAX_REQ-1:0] pick_ext;
  logic               grant_fire;
  logic               timeout;

  // Timepulse counter; the slot boundary is the last timepulse of the slot.
  assign slot_end = (tp_q == TP_W'(CYCLE_LEN - 1));

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      tp_q <= '0;
    end else if (slot_end) begin
      tp_q <= '0;
    end else begin
      tp_q <= tp_q + 1'b1;
    end
  end

  always_comb begin
    pend_ext             = '0;
    pend_ext[NREQ-1:0]   = pend;
    pick_ext             = onehot_lowest(pend_ext);
    pick                 = pick_ext[NREQ-1:0];
  end

  assign grant_fire = (state_q == SCHED_IDLE) && slot_end && !INHINC && (pend != '0);
  // CTR_DONE arriving on the final boundary completes the cycle rather than timing out.
  assign timeout    = (state_q == SCHED_BUSY) && !CTR_DONE && slot_end &&
                      (slot_cnt_q == 4'(TIMEOUT_SLOTS - 1));
  assign gnt_now    = grant_fire ? pick : '0;
  assign retry_vec  = timeout ? gnt_q : '0;

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q    <= SCHED_IDLE;
      vld_q      <= 1'b0;
      gnt_q      <= '0;
      slot_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (timeout) begin
        err_q <= 1'b1;
      end else if (CLR_LOST) begin
        err_q <= 1'b0;
      end

      case (state_q)
        SCHED_IDLE: begin
          if (grant_fire) begin
            state_q    <= SCHED_BUSY;
            vld_q      <= 1'b1;
            gnt_q      <= pick;
            slot_cnt_q <= '0;
          end
        end
        SCHED_BUSY: begin
          if (CTR_DONE || timeout) begin
            state_q <= SCHED_IDLE;
            vld_q   <= 1'b0;
            gnt_q   <= '0;
          end else if (slot_end) begin
            slot_cnt_q <= slot_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= SCHED_IDLE;
          vld_q   <= 1'b0;
          gnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef SCALER_SCHED_LOSS_COUNT_EN
  logic [NREQ-1:0] lost_evt;
  logic            any_lost;
  logic [7:0]      loss_cnt_q;

  assign any_lost = (lost_evt != '0);

  // A lost event in the same clock as CLR_LOST is still counted.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      loss_cnt_q <= '0;
    end else if (CLR_LOST) begin
      loss_cnt_q <= {7'd0, any_lost};
    end else if (any_lost && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign LOSS_CNT = loss_cnt_q;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    scaler_edge_latch u_latch (
      .clk      (SIM_CLK),
      .rst      (SIM_RST),
      .tap      (SCL_TAP[g]),
      .en       (REQ_EN[g]),
      .gnt      (gnt_now[g]),
      .retry    (retry_vec[g]),
      .clr_lost (CLR_LOST),
      .pend     (pend[g]),
      .lost     (lost[g])
`ifdef SCALER_SCHED_LOSS_COUNT_EN
      ,
      .lost_evt (lost_evt[g])
`endif
    );
  end

  assign TP      = tp_q;
  assign CTR_VLD = vld_q;
  assign CTR_GNT = gnt_q;
  assign PEND    = pend;
  assign LOST    = lost;
  assign ERR     = err_q;

endmodule

// File: tb/tb_scaler_counter_scheduler.sv
// Directed bench for scaler_counter_scheduler with hand-computed expectations.
module tb_scaler_counter_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scl_tap;
  logic [7:0] req_en;
  logic       inhinc;
  logic       ctr_done;
  logic       clr_lost;
  logic [3:0] tp;
  logic       ctr_vld;
  logic [7:0] ctr_gnt;
  logic [7:0] pend;
  logic [7:0] lost;
  logic       err;
`ifdef SCALER_SCHED_LOSS_COUNT_EN
  logic [7:0] loss_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned tb_tp    = 0;

  always #5 clk = ~clk;

  scaler_counter_scheduler #(
    .NREQ          (8),
    .CYCLE_LEN     (12),
    .TIMEOUT_SLOTS (4)
  ) dut (
    .SIM_CLK  (clk),
    .SIM_RST  (rst),
    .SCL_TAP  (scl_tap),
    .REQ_EN   (req_en),
    .INHINC   (inhinc),
    .CTR_DONE (ctr_done),
    .CLR_LOST (clr_lost),
    .TP       (tp),
    .CTR_VLD  (ctr_vld),
    .CTR_GNT  (ctr_gnt),
    .PEND     (pend),
    .LOST     (lost),
    .ERR      (err)
`ifdef SCALER_SCHED_LOSS_COUNT_EN
    ,
    .LOSS_CNT (loss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // One clock; inputs set before the call are sampled on this edge.
  task automatic step();
    @(posedge clk);
    #1;
    tb_tp = (tb_tp + 1) % 12;
  endtask

  task automatic goto_tp(input int unsigned v);
    while (tb_tp != v) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; scl_tap = '0; req_en = 8'hFF; inhinc = 1'b0;
    ctr_done = 1'b0; clr_lost = 1'b0;
    step(); step();
    tb_tp = 0;
    check("rst_tp", 32'(tp), 32'd0);
    check("rst_vld", 32'(ctr_vld), 32'd0);
    check("rst_gnt", 32'(ctr_gnt), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Single request on bit 3
    goto_tp(2);
    scl_tap = 8'h08;
    step();
    check("single_tp3", 32'(tp), 32'd3);
    check("single_pend", 32'(pend), 32'h08);
    scl_tap = 8'h00;
    goto_tp(11);
    check("single_tp11", 32'(tp), 32'd11);
    check("single_vld_pre", 32'(ctr_vld), 32'd0);
    step();
    check("single_tp_wrap", 32'(tp), 32'd0);
    check("single_vld", 32'(ctr_vld), 32'd1);
    check("single_gnt", 32'(ctr_gnt), 32'h08);
    check("single_pend_clr", 32'(pend), 32'h00);
    goto_tp(4);
    ctr_done = 1'b1;
    step();
    ctr_done = 1'b0;
    check("single_done_vld", 32'(ctr_vld), 32'd0);
    check("single_done_gnt", 32'(ctr_gnt), 32'h00);
    check("single_done_pend", 32'(pend), 32'h00);

    // Priority: bits 5 and 1 in the same slot
    scl_tap = 8'h22;
    step();
    check("prio_pend", 32'(pend), 32'h22);
    goto_tp(11);
    step();
    check("prio_gnt1", 32'(ctr_gnt), 32'h02);
    check("prio_pend1", 32'(pend), 32'h20);
    ctr_done = 1'b1;
    step();
    ctr_done = 1'b0;
    check("prio_idle", 32'(ctr_vld), 32'd0);
    goto_tp(11);
    check("prio_wait", 32'(ctr_vld), 32'd0);
    step();
    check("prio_gnt2", 32'(ctr_gnt), 32'h20);
    check("prio_vld2", 32'(ctr_vld), 32'd1);
    check("prio_lost", 32'(lost), 32'h00);
    ctr_done = 1'b1;
    step();
    ctr_done = 1'b0;
    scl_tap = 8'h00;
    step();

    // Lost increment under INHINC on bit 2
    inhinc = 1'b1;
    scl_tap = 8'h04;
    step();
    check("lost_pend1", 32'(pend), 32'h04);
    check("lost_none", 32'(lost), 32'h00);
    scl_tap = 8'h00;
    step();
    scl_tap = 8'h04;
    step();
    check("lost_pend2", 32'(pend), 32'h04);
    check("lost_set", 32'(lost), 32'h04);
`ifdef SCALER_SCHED_LOSS_COUNT_EN
    check("loss_cnt1", 32'(loss_cnt), 32'd1);
`endif
    scl_tap = 8'h00;
    step();
    scl_tap = 8'h04;
    clr_lost = 1'b1;
    step();
    check("lost_clr_collide", 32'(lost), 32'h04);
`ifdef SCALER_SCHED_LOSS_COUNT_EN
    check("loss_cnt_collide", 32'(loss_cnt), 32'd1);
`endif
    step();
    clr_lost = 1'b0;
    check("lost_cleared", 32'(lost), 32'h00);
`ifdef SCALER_SCHED_LOSS_COUNT_EN
    check("loss_cnt_cleared", 32'(loss_cnt), 32'd0);
`endif
    goto_tp(11);
    step();
    check("inhinc_no_grant", 32'(ctr_vld), 32'd0);
    check("inhinc_pend", 32'(pend), 32'h04);
    req_en = 8'hFB;
    scl_tap = 8'h00;
    step();
    check("mask_clr_pend2", 32'(pend), 32'h00);
    req_en = 8'hFF;
    inhinc = 1'b0;

    // Timeout on bit 0
    scl_tap = 8'h01;
    step();
    check("to_pend", 32'(pend), 32'h01);
    goto_tp(11);
    step();
    check("to_gnt", 32'(ctr_gnt), 32'h01);
    for (int k = 1; k <= 3; k++) begin
      goto_tp(11);
      step();
      check("to_still_busy", 32'(ctr_vld), 32'd1);
    end
    goto_tp(11);
    step();
    check("to_vld", 32'(ctr_vld), 32'd0);
    check("to_err", 32'(err), 32'd1);
    check("to_retry_pend", 32'(pend), 32'h01);
    check("to_gnt_clr", 32'(ctr_gnt), 32'h00);
    goto_tp(11);
    clr_lost = 1'b1;
    step();
    clr_lost = 1'b0;
    check("to_regrant_vld", 32'(ctr_vld), 32'd1);
    check("to_regrant_gnt", 32'(ctr_gnt), 32'h01);
    check("to_err_clr", 32'(err), 32'd0);

    // Reset while busy with all taps high
    step();
    scl_tap = 8'hFF;
    rst = 1'b1;
    step();
    tb_tp = 0;
    check("mid_rst_vld", 32'(ctr_vld), 32'd0);
    check("mid_rst_gnt", 32'(ctr_gnt), 32'h00);
    check("mid_rst_pend", 32'(pend), 32'h00);
    check("mid_rst_tp", 32'(tp), 32'd0);
    rst = 1'b0;
    step();
    step();
    check("post_rst_pend", 32'(pend), 32'h00);
    check("post_rst_tp", 32'(tp), 32'd2);

    // Edge on bit 4 in its own grant clock, then mask it
    scl_tap = 8'h00;
    step();
    scl_tap = 8'h10;
    step();
    check("sim_pend", 32'(pend), 32'h10);
    goto_tp(10);
    scl_tap = 8'h00;
    step();
    scl_tap = 8'h10;
    step();
    check("sim_gnt", 32'(ctr_gnt), 32'h10);
    check("sim_pend_kept", 32'(pend), 32'h10);
    check("sim_no_lost", 32'(lost), 32'h00);
    ctr_done = 1'b1;
    step();
    ctr_done = 1'b0;
    check("sim_done", 32'(ctr_vld), 32'd0);
    req_en = 8'hEF;
    step();
    check("sim_mask_clr", 32'(pend), 32'h00);
    check("sim_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
